// File: rtl/weight_mac_receiver_if.sv
// Loader/controller bundle for the weight MAC receiver: weight writes, run request, status back.
interface weight_mac_receiver_if;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic [31:0] x_in;
    logic        busy;
    logic        done;
    logic [3:0]  unit_out;
    logic [3:0]  loaded;
    logic        start_err;
    logic        wr_drop;

    modport master (
        output wr_en, wr_addr, wr_data, start, x_in,
        input  busy, done, unit_out, loaded, start_err, wr_drop
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, x_in,
        output busy, done, unit_out, loaded, start_err, wr_drop
    );
endinterface

// File: rtl/weight_mac_receiver.sv
// Weight bank plus sequential 4-unit x 4-input signed MAC layer with threshold activation.
// One product per cycle; each unit takes 4 MAC cycles plus one activation cycle.
module weight_mac_receiver #(
    parameter int unsigned ACC_W  = 18,
    parameter int signed   THRESH = 0
) (
    input logic             clk,
    input logic             reset,
    weight_mac_receiver_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;

    localparam logic signed [ACC_W-1:0] THRESH_V = ACC_W'(THRESH);

    state_t                  state_q;
    logic [31:0]             w_q [4];
    logic [31:0]             x_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [1:0]              u_q;
    logic [1:0]              j_q;
    logic [3:0]              loaded_q;
    logic [3:0]              result_q;
    logic [3:0]              unit_out_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    start_err_q;
    logic                    wr_drop_q;

    logic signed [7:0]       w_byte;
    logic signed [7:0]       x_byte;
    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] acc_d;
    logic                    fire;
    logic [3:0]              result_d;

    // Datapath: current weight/input byte, product, running sum and activation bit.
    always_comb begin
        w_byte   = w_q[u_q][{j_q, 3'b000} +: 8];
        x_byte   = x_q[{j_q, 3'b000} +: 8];
        prod     = w_byte * x_byte;
        acc_d    = acc_q + ACC_W'(prod);
        fire     = (acc_q > THRESH_V);
        result_d = result_q;
        result_d[u_q] = fire;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            for (int i = 0; i < 4; i++) w_q[i] <= '0;
            x_q         <= '0;
            acc_q       <= '0;
            u_q         <= '0;
            j_q         <= '0;
            loaded_q    <= '0;
            result_q    <= '0;
            unit_out_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            wr_drop_q   <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            wr_drop_q   <= 1'b0;

            // Writes land only while idle; the start check below sees the pre-edge loaded mask.
            if (bus.wr_en) begin
                if (state_q == IDLE) begin
                    w_q[bus.wr_addr]      <= bus.wr_data;
                    loaded_q[bus.wr_addr] <= 1'b1;
                end else begin
                    wr_drop_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (loaded_q == 4'hF) begin
                            x_q     <= bus.x_in;
                            acc_q   <= '0;
                            u_q     <= '0;
                            j_q     <= '0;
                            busy_q  <= 1'b1;
                            state_q <= MAC;
                        end else begin
                            start_err_q <= 1'b1;
                        end
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    j_q   <= j_q + 2'd1;
                    if (j_q == 2'd3) state_q <= ACT;
                end
                ACT: begin
                    result_q <= result_d;
                    acc_q    <= '0;
                    j_q      <= '0;
                    if (u_q == 2'd3) begin
                        unit_out_q <= result_d;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        u_q     <= u_q + 2'd1;
                        state_q <= MAC;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.unit_out  = unit_out_q;
    assign bus.loaded    = loaded_q;
    assign bus.start_err = start_err_q;
    assign bus.wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_weight_mac_receiver.sv
// Directed bench for weight_mac_receiver: hand-computed layer results, latency and error pulses.
module tb_weight_mac_receiver;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_mis = 0;

    weight_mac_receiver_if bus ();

    weight_mac_receiver #(.ACC_W(18), .THRESH(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic load4(input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
        wr(2'd0, d0);
        wr(2'd1, d1);
        wr(2'd2, d2);
        wr(2'd3, d3);
    endtask

    // Waits for done (bounded) after the start edge, counting edges and busy cycles.
    task automatic wait_done(input string tag, input logic [3:0] exp_units, input bit poke);
        int n_edges = 0;
        int n_busy  = 0;
        if (bus.busy) n_busy++;
        while (!bus.done && n_edges < 40) begin
            if (poke && n_edges == 6) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 2'd1;
                bus.wr_data = 32'hFFFF_FFFF;
                bus.start   = 1'b1;
            end
            tick();
            n_edges++;
            if (bus.busy) n_busy++;
            if (poke && n_edges == 7) begin
                bus.wr_en = 1'b0;
                bus.start = 1'b0;
                check_eq({tag, " wr_drop"}, 32'(bus.wr_drop), 32'd1);
                check_eq({tag, " no_start_err"}, 32'(bus.start_err), 32'd0);
                check_eq({tag, " loaded_kept"}, 32'(bus.loaded), 32'hF);
            end
            if (poke && n_edges == 8)
                check_eq({tag, " wr_drop_1cyc"}, 32'(bus.wr_drop), 32'd0);
        end
        check_eq({tag, " latency"}, 32'(n_edges), 32'd20);
        check_eq({tag, " busy_cycles"}, 32'(n_busy), 32'd21);
        check_eq({tag, " unit_out"}, 32'(bus.unit_out), 32'(exp_units));
        tick();
        check_eq({tag, " done_1cyc"}, 32'(bus.done), 32'd0);
        check_eq({tag, " busy_clr"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] x, input logic [3:0] exp_units,
                       input bit poke);
        bus.start = 1'b1;
        bus.x_in  = x;
        tick();
        bus.start = 1'b0;
        bus.x_in  = 32'hDEAD_BEEF;
        wait_done(tag, exp_units, poke);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        bus.x_in    = '0;
        reset       = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check_eq("rst busy", 32'(bus.busy), 32'd0);
        check_eq("rst done", 32'(bus.done), 32'd0);
        check_eq("rst unit_out", 32'(bus.unit_out), 32'd0);
        check_eq("rst loaded", 32'(bus.loaded), 32'd0);
        check_eq("rst start_err", 32'(bus.start_err), 32'd0);
        check_eq("rst wr_drop", 32'(bus.wr_drop), 32'd0);

        // All ones weights, x = 1,2,3,4 -> acc 10 each.
        load4(32'h0101_0101, 32'h0101_0101, 32'h0101_0101, 32'h0101_0101);
        check_eq("t1 loaded", 32'(bus.loaded), 32'hF);
        run("t1", 32'h0403_0201, 4'b1111, 1'b0);

        // accs 4, -4, 0, 508 -> u0 and u3 fire.
        load4(32'h0101_0101, 32'hFFFF_FFFF, 32'h0000_0000, 32'h7F7F_7F7F);
        run("t2", 32'h0101_0101, 4'b1001, 1'b0);

        // acc0 = 65536 fires, acc1 = -65024 does not.
        load4(32'h8080_8080, 32'h7F7F_7F7F, 32'h0000_0000, 32'h0000_0000);
        run("t3", 32'h8080_8080, 4'b0001, 1'b0);

        // Same run with a dropped write and an ignored start mid-run.
        run("t5", 32'h8080_8080, 4'b0001, 1'b1);
        check_eq("t5 start_err_after", 32'(bus.start_err), 32'd0);

        // Reset at cycle 10 of a run.
        bus.start = 1'b1;
        bus.x_in  = 32'h8080_8080;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        check_eq("t6 busy_mid", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t6 busy", 32'(bus.busy), 32'd0);
        check_eq("t6 loaded", 32'(bus.loaded), 32'd0);
        check_eq("t6 unit_out", 32'(bus.unit_out), 32'd0);
        begin
            int n_done = 0;
            for (int k = 0; k < 25; k++) begin
                if (bus.done) n_done++;
                tick();
            end
            check_eq("t6 no_done", 32'(n_done), 32'd0);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("t6 start_err", 32'(bus.start_err), 32'd1);
        check_eq("t6 stay_idle", 32'(bus.busy), 32'd0);

        // Partial load: start rejected; final word arriving with start still rejected.
        wr(2'd0, 32'h0101_0101);
        wr(2'd1, 32'h0101_0101);
        wr(2'd2, 32'h0101_0101);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("t4 start_err1", 32'(bus.start_err), 32'd1);
        check_eq("t4 busy1", 32'(bus.busy), 32'd0);
        check_eq("t4 unit_out", 32'(bus.unit_out), 32'd0);
        tick();
        check_eq("t4 start_err_1cyc", 32'(bus.start_err), 32'd0);
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd3;
        bus.wr_data = 32'hFFFF_FFFF;
        tick();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        check_eq("t4 start_err2", 32'(bus.start_err), 32'd1);
        check_eq("t4 busy2", 32'(bus.busy), 32'd0);
        check_eq("t4 loaded", 32'(bus.loaded), 32'hF);
        // accs 4, 4, 4, -4.
        run("t4", 32'h0101_0101, 4'b0111, 1'b0);

        // Fully loaded: concurrent write and start uses the new word (u3 -> +4).
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd3;
        bus.wr_data = 32'h0101_0101;
        bus.start   = 1'b1;
        bus.x_in    = 32'h0101_0101;
        tick();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        check_eq("t7 no_start_err", 32'(bus.start_err), 32'd0);
        check_eq("t7 no_wr_drop", 32'(bus.wr_drop), 32'd0);
        wait_done("t7", 4'b1111, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/weight_mac_receiver.md
Name: weight_mac_receiver

Overview:
- Receiving end of the ROM-to-network weight load interface.
- Accepts up to four 32-bit weight words over the address/write-strobe interface into an internal weight bank, one word per unit.
- On a one-cycle start pulse, runs a sequential 4-unit x 4-input signed multiply-accumulate layer with threshold activation.
- Presents a 4-bit unit result vector and a done pulse.

Parameters:
- ACC_W, 18, accumulator width in bits. Minimum 18 so that 4 x (-128 x -128) = 65536 fits.
- THRESH, 0, signed activation threshold. A unit fires when acc > THRESH (strictly greater).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wr_en  in  1  write strobe from the loader (writeData)
- wr_addr  in  2  unit index of the weight word
- wr_data  in  32  weight word: four signed 8-bit weights, byte j = bits [8j+7:8j]
- start  in  1  one-cycle run request (start_network_controller)
- x_in  in  32  four signed 8-bit inputs, byte j = bits [8j+7:8j]; sampled only when start is accepted
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  one-cycle pulse; results valid
- unit_out  out  4  bit u = activation of unit u; held until next done or reset
- loaded  out  4  bit u set once unit u's word has been written since reset
- start_err  out  1  one-cycle pulse: start rejected because loaded != 4'hF
- wr_drop  out  1  one-cycle pulse: write ignored because busy

Behaviour:
- Reset values: state IDLE; busy, done, start_err, wr_drop = 0; unit_out = 0; loaded = 0; all weight words = 0; accumulator, unit index u and input index j = 0. Reset mid-run aborts immediately with no done pulse.
- Write, IDLE only: at an edge with wr_en=1, weight[wr_addr] <= wr_data and loaded[wr_addr] <= 1. Rewriting an address overwrites it.
- Write while busy: no change to weights or loaded; wr_drop=1 in the following cycle.
- FSM states: IDLE, MAC, ACT, DONE.
- IDLE: if start=1 and loaded==4'hF at edge E0, then latch x_in, acc<=0, u<=0, j<=0, go to MAC. If start=1 and loaded!=4'hF, stay in IDLE and pulse start_err the next cycle.
- MAC: each edge, acc <= acc + sext(w[u][j] * x[j]), using an 8x8 signed multiply giving a 16-bit product sign-extended to ACC_W; j++. After j=3 is consumed, go to ACT (4 cycles).
- ACT: result[u] <= (signed acc > THRESH); acc<=0; j<=0. If u==3, unit_out <= result (including the new bit) and go to DONE; else u++ and go to MAC.
- DONE: done=1 for exactly this cycle, then IDLE.
- Latency: start accepted at E0; unit u evaluated at edge E(5u+5); done is high in the cycle between E20 and E21; busy is high from after E0 through the DONE cycle (21 cycles).
- Simultaneous start and wr_en in IDLE:
  - The write commits at E0.
  - The loaded check uses the pre-edge value, so a start that arrives with the final missing word is rejected with start_err.
  - If already fully loaded, start is accepted and the run uses the newly written word.
- start while busy: ignored, no start_err.
- unit_out changes only at the transition to DONE; it is never partially updated.
- No saturation is needed or performed: with ACC_W=18 the range [-65024, 65536] is exact.

Test Plan:
- Load 0x01010101 to addresses 0..3, x_in=0x04030201, start -> each acc=10; done 21 cycles after start accepted; unit_out=4'b1111; busy high 21 cycles.
- Weights u0=0x01010101, u1=0xFFFFFFFF, u2=0x00000000, u3=0x7F7F7F7F, x_in=0x01010101 -> accs 4, -4, 0, 508; unit_out=4'b1001 (u2 at 0 does not fire).
- Extreme values: u0=0x80808080, u1=0x7F7F7F7F, others 0, x_in=0x80808080 -> acc0=65536 fires, acc1=-65024 does not; unit_out=4'b0001; catches 17-bit overflow.
- Load only addresses 0..2, start -> start_err pulse, busy stays 0, unit_out unchanged; write address 3 concurrently with a second start -> start_err again; third start -> run proceeds.
- During a run, wr_en to address 1 with 0xFFFFFFFF -> wr_drop pulse, weight unchanged, same unit_out as the previous run; start during busy is ignored.
- Assert reset at cycle 10 of a run -> next cycle busy=0, loaded=0, unit_out=0, no done; start without reloading -> start_err.
